// File: rtl/row_window_streamer.sv
// Three-row sliding window front/back end for the Life row accelerator: rows in, window to the
// next-state array, registered result rows out (one per input row, in order, zero-padded frame edges).
module row_window_streamer #(
  parameter int row_length = 1280,
  parameter int num_rows   = 720
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [row_length-1:0] s_row_data,
  input  logic                  s_row_valid,
  output logic                  s_row_ready,
  output logic [row_length-1:0] top_row,
  output logic [row_length-1:0] middle_row,
  output logic [row_length-1:0] bottom_row,
  input  logic [row_length-1:0] next_row,
  output logic [row_length-1:0] m_row_data,
  output logic                  m_row_valid,
  input  logic                  m_row_ready,
  output logic                  m_row_last
);

  localparam int            CW       = $clog2(num_rows + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(num_rows - 1);
  localparam logic [CW-1:0] ROWS     = CW'(num_rows);

  typedef enum logic [1:0] {LOAD0, LOAD, EMIT} state_t;

  state_t                state_q, state_d;
  logic [row_length-1:0] top_q, top_d;
  logic [row_length-1:0] mid_q, mid_d;
  logic [row_length-1:0] bot_q, bot_d;
  logic [CW-1:0]         in_cnt_q, in_cnt_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic [row_length-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;

  logic accept;
  logic slot_free;
  logic capture;
  logic last_out;

  assign s_row_ready = resetn && (state_q != EMIT);
  assign accept      = s_row_valid && s_row_ready;
  assign slot_free   = !m_valid_q || m_row_ready;
  assign capture     = (state_q == EMIT) && slot_free;
  assign last_out    = (out_cnt_q == LAST_IDX);

  assign top_row     = top_q;
  assign middle_row  = mid_q;
  assign bottom_row  = bot_q;
  assign m_row_data  = m_data_q;
  assign m_row_valid = m_valid_q;
  assign m_row_last  = m_last_q;

  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    mid_d     = mid_q;
    bot_d     = bot_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      LOAD0: begin
        if (accept) begin
          top_d    = '0;
          mid_d    = s_row_data;
          bot_d    = '0;
          in_cnt_d = CW'(1);
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          bot_d    = s_row_data;
          in_cnt_d = in_cnt_q + CW'(1);
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (capture) begin
          top_d     = mid_q;
          mid_d     = bot_q;
          bot_d     = '0;
          out_cnt_d = out_cnt_q + CW'(1);
          if (last_out) begin
            state_d   = LOAD0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
          end else if (in_cnt_q == ROWS) begin
            // Every row is in; keep emitting with a zero row below the frame edge.
            state_d = EMIT;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD0;
    endcase
  end

  // A capture on the same edge as a downstream handshake simply replaces the old row.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    if (capture) begin
      m_data_d  = next_row;
      m_valid_d = 1'b1;
      m_last_d  = last_out;
    end else if (m_row_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= LOAD0;
      top_q     <= '0;
      mid_q     <= '0;
      bot_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      top_q     <= top_d;
      mid_q     <= mid_d;
      bot_q     <= bot_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

endmodule

// File: tb/tb_row_window_streamer.sv
// Directed bench for row_window_streamer: three instances (3, 4 and 2 rows per frame, 8-cell rows)
// share stimulus; a Life next-state function stands in for the array.
module tb_row_window_streamer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] s_row_data;
  logic       s_row_valid;
  logic       m_row_ready;

  logic       srdy_w [3];
  logic [7:0] top_w  [3];
  logic [7:0] mid_w  [3];
  logic [7:0] bot_w  [3];
  logic [7:0] next_w [3];
  logic [7:0] mdat_w [3];
  logic       mvld_w [3];
  logic       mlast_w[3];

  logic [1:0] sel = 2'd0;
  logic       srdy_s, mvld_s, mlast_s;
  logic [7:0] top_s, mid_s, bot_s, mdat_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  od[$];
  logic        ol[$];
  int          oc[$];
  logic [23:0] wq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] life(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    logic [7:0] r;
    int n;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      for (int j = i - 1; j <= i + 1; j++) begin
        if (j >= 0 && j < 8) begin
          n += int'(t[j]) + int'(b[j]);
          if (j != i) n += int'(m[j]);
        end
      end
      r[i] = (n == 3) || (m[i] && n == 2);
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NR = (g == 0) ? 3 : ((g == 1) ? 4 : 2);
    assign next_w[g] = life(top_w[g], mid_w[g], bot_w[g]);
    row_window_streamer #(.row_length(8), .num_rows(NR)) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .s_row_data  (s_row_data),
      .s_row_valid (s_row_valid),
      .s_row_ready (srdy_w[g]),
      .top_row     (top_w[g]),
      .middle_row  (mid_w[g]),
      .bottom_row  (bot_w[g]),
      .next_row    (next_w[g]),
      .m_row_data  (mdat_w[g]),
      .m_row_valid (mvld_w[g]),
      .m_row_ready (m_row_ready),
      .m_row_last  (mlast_w[g])
    );
  end

  assign srdy_s  = srdy_w[sel];
  assign mvld_s  = mvld_w[sel];
  assign mlast_s = mlast_w[sel];
  assign mdat_s  = mdat_w[sel];
  assign top_s   = top_w[sel];
  assign mid_s   = mid_w[sel];
  assign bot_s   = bot_w[sel];

  // Observe 1 ns before each rising edge: window at capture edges, rows at output handshakes.
  always begin
    @(negedge clk);
    #4;
    if (resetn) begin
      if (!srdy_s && (!mvld_s || m_row_ready)) wq.push_back({top_s, mid_s, bot_s});
      if (mvld_s && m_row_ready) begin
        od.push_back(mdat_s);
        ol.push_back(mlast_s);
        oc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    od.delete(); ol.delete(); oc.delete(); wq.delete();
  endtask

  task automatic send(input logic [7:0] d);
    bit done;
    done        = 1'b0;
    s_row_data  = d;
    s_row_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (srdy_s) done = 1'b1;
      @(negedge clk);
    end
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    s_row_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    s_row_valid = 1'b0;
    resetn      = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    clear_q();
  endtask

  task automatic expect_out(input string tag, input int i, input logic [7:0] d, input logic l);
    chk({tag, "_data"}, (i < od.size()) ? 32'(od[i]) : 32'hFFFF_FFFF, 32'(d));
    chk({tag, "_last"}, (i < ol.size()) ? 32'(ol[i]) : 32'hFFFF_FFFF, 32'(l));
  endtask

  task automatic expect_win(input string tag, input int i, input logic [23:0] w);
    chk(tag, (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF, 32'(w));
  endtask

  function automatic int gap(input int i);
    return (i < oc.size()) ? oc[i] - oc[i-1] : -1;
  endfunction

  initial begin
    resetn      = 1'b0;
    s_row_data  = '0;
    s_row_valid = 1'b0;
    m_row_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_srdy", 32'(srdy_s), 32'd0);
    chk("rst_mvld", 32'(mvld_s), 32'd0);
    chk("rst_mdat", 32'(mdat_s), 32'd0);
    chk("rst_mlast", 32'(mlast_s), 32'd0);
    chk("rst_win", 32'({top_s, mid_s, bot_s}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_srdy", 32'(srdy_s), 32'd1);
    clear_q();

    // Blinker, 3 rows
    sel = 2'd0;
    send(8'h08); send(8'h08); send(8'h08);
    idle(10);
    chk("blk_count", 32'(od.size()), 32'd3);
    expect_out("blk0", 0, 8'h00, 1'b0);
    expect_out("blk1", 1, 8'h1C, 1'b0);
    expect_out("blk2", 2, 8'h00, 1'b1);
    chk("blk_srdy_after", 32'(srdy_s), 32'd1);

    // Window trace, 4 rows
    sel = 2'd1;
    do_reset();
    send(8'hA5); send(8'h3C); send(8'hFF); send(8'h0F);
    idle(10);
    chk("win_count", 32'(wq.size()), 32'd4);
    expect_win("win0", 0, 24'h00A53C);
    expect_win("win1", 1, 24'hA53CFF);
    expect_win("win2", 2, 24'h3CFF0F);
    expect_win("win3", 3, 24'hFF0F00);
    chk("win_out_count", 32'(od.size()), 32'd4);
    chk("win_last2", (2 < ol.size()) ? 32'(ol[2]) : 32'hFFFF_FFFF, 32'd0);
    chk("win_last3", (3 < ol.size()) ? 32'(ol[3]) : 32'hFFFF_FFFF, 32'd1);

    // Backpressure on a blinker frame
    sel = 2'd0;
    m_row_ready = 1'b0;
    do_reset();
    send(8'h08); send(8'h08); send(8'h08);
    s_row_valid = 1'b0;
    for (int n = 0; n < 20 && !mvld_s; n++) @(negedge clk);
    chk("bp_vld_seen", 32'(mvld_s), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(mdat_s), 32'h00);
      chk("bp_hold_vld", 32'(mvld_s), 32'd1);
      chk("bp_hold_last", 32'(mlast_s), 32'd0);
      chk("bp_srdy_low", 32'(srdy_s), 32'd0);
    end
    m_row_ready = 1'b1;
    idle(10);
    chk("bp_count", 32'(od.size()), 32'd3);
    expect_out("bp0", 0, 8'h00, 1'b0);
    expect_out("bp1", 1, 8'h1C, 1'b0);
    expect_out("bp2", 2, 8'h00, 1'b1);

    // Minimum frame, 2 rows
    sel = 2'd2;
    do_reset();
    send(8'h81); send(8'h81);
    idle(10);
    chk("min_win_count", 32'(wq.size()), 32'd2);
    expect_win("min_win0", 0, 24'h008181);
    expect_win("min_win1", 1, 24'h818100);
    chk("min_count", 32'(od.size()), 32'd2);
    expect_out("min0", 0, 8'h00, 1'b0);
    expect_out("min1", 1, 8'h00, 1'b1);
    chk("min_srdy_after", 32'(srdy_s), 32'd1);

    // Reset mid-frame, 4 rows
    sel = 2'd1;
    do_reset();
    send(8'h08); send(8'h08);
    s_row_valid = 1'b0;
    resetn      = 1'b0;
    @(negedge clk);
    chk("mid_rst_mvld", 32'(mvld_s), 32'd0);
    chk("mid_rst_srdy", 32'(srdy_s), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    clear_q();
    send(8'h08); send(8'h08); send(8'h08); send(8'h00);
    idle(10);
    chk("mid_count", 32'(od.size()), 32'd4);
    expect_out("mid0", 0, 8'h00, 1'b0);
    expect_out("mid1", 1, 8'h1C, 1'b0);
    expect_out("mid2", 2, 8'h00, 1'b0);
    expect_out("mid3", 3, 8'h00, 1'b1);

    // Back-to-back blinker frames with the input always offering a row
    sel = 2'd0;
    do_reset();
    for (int f = 0; f < 6; f++) send(8'h08);
    idle(12);
    chk("b2b_count", 32'(od.size()), 32'd6);
    expect_out("b2b0", 0, 8'h00, 1'b0);
    expect_out("b2b1", 1, 8'h1C, 1'b0);
    expect_out("b2b2", 2, 8'h00, 1'b1);
    expect_out("b2b3", 3, 8'h00, 1'b0);
    expect_out("b2b4", 4, 8'h1C, 1'b0);
    expect_out("b2b5", 5, 8'h00, 1'b1);
    // Frame cadence LOAD0,LOAD,EMIT,LOAD,EMIT,EMIT: the flush row follows 1 cycle after its
    // predecessor and the next frame's first row arrives 3 cycles after the flush row.
    chk("b2b_gap1", 32'(gap(1)), 32'd2);
    chk("b2b_gap2", 32'(gap(2)), 32'd1);
    chk("b2b_gap3", 32'(gap(3)), 32'd3);
    chk("b2b_gap4", 32'(gap(4)), 32'd2);
    chk("b2b_gap5", 32'(gap(5)), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
